// File: rtl/io_sequencer.sv
// Pushbutton-driven operand entry and datapath launch sequencer.
// Buttons are synchronized and edge-detected; a small FSM runs one datapath transaction per calculate press.
module io_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        shift,
    input  logic        calculate,
    input  logic [3:0]  switch,
    output logic [15:0] dp_operand,
    output logic        dp_start,
    input  logic        dp_done,
    input  logic [15:0] dp_result,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        busy,
    output logic        timeout
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_r;
    logic [CW-1:0]  cnt_r;
    logic           shift_meta_r;
    logic           shift_sync_r;
    logic           shift_hist_r;
    logic           calc_meta_r;
    logic           calc_sync_r;
    logic           calc_hist_r;
    logic [15:0]    dp_operand_r;
    logic [15:0]    result_r;
    logic           dp_start_r;
    logic           result_valid_r;
    logic           busy_r;
    logic           timeout_r;
    logic           shift_edge_s;
    logic           calc_edge_s;

    assign shift_edge_s = shift_sync_r & ~shift_hist_r;
    assign calc_edge_s  = calc_sync_r & ~calc_hist_r;

    assign dp_operand   = dp_operand_r;
    assign result       = result_r;
    assign dp_start     = dp_start_r;
    assign result_valid = result_valid_r;
    assign busy         = busy_r;
    assign timeout      = timeout_r;

    // Button synchronizers, sequencer FSM and its registered state-decoded outputs.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_r        <= IDLE;
            cnt_r          <= '0;
            shift_meta_r   <= 1'b0;
            shift_sync_r   <= 1'b0;
            shift_hist_r   <= 1'b0;
            calc_meta_r    <= 1'b0;
            calc_sync_r    <= 1'b0;
            calc_hist_r    <= 1'b0;
            dp_operand_r   <= 16'h0000;
            result_r       <= 16'h0000;
            dp_start_r     <= 1'b0;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            timeout_r      <= 1'b0;
        end else begin
            shift_meta_r <= shift;
            shift_sync_r <= shift_meta_r;
            shift_hist_r <= shift_sync_r;
            calc_meta_r  <= calculate;
            calc_sync_r  <= calc_meta_r;
            calc_hist_r  <= calc_sync_r;

            // Outputs are set on the transition into the state they decode, so they track state exactly.
            case (state_r)
                IDLE: begin
                    if (calc_edge_s) begin
                        timeout_r  <= 1'b0;
                        cnt_r      <= '0;
                        dp_start_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= START;
                    end else if (shift_edge_s) begin
                        dp_operand_r <= {dp_operand_r[11:0], switch};
                    end
                end
                START: begin
                    dp_start_r <= 1'b0;
                    state_r    <= WAIT;
                end
                WAIT: begin
                    if (dp_done) begin
                        result_r       <= dp_result;
                        result_valid_r <= 1'b1;
                        state_r        <= DONE;
                    end else if (cnt_r == CNT_MAX) begin
                        result_r       <= 16'hFFFF;
                        timeout_r      <= 1'b1;
                        result_valid_r <= 1'b1;
                        state_r        <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    result_valid_r <= 1'b0;
                    busy_r         <= 1'b0;
                    state_r        <= IDLE;
                end
                default: begin
                    dp_start_r     <= 1'b0;
                    result_valid_r <= 1'b0;
                    busy_r         <= 1'b0;
                    state_r        <= IDLE;
                end
            endcase
        end
    end

endmodule
